// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - bus-side interface of the PS/2 receive FIFO
//
// Groups the register-bus facing signals of ps2_rx_fifo.
//   RD     : one-cycle pop strobe (bus -> fifo)
//   CLR    : one-cycle clear of sticky error flags (bus -> fifo)
//   RDATA  : head-of-FIFO byte, 8'h00 when empty (fifo -> bus)
//   EMPTY  : FIFO holds no entries
//   FULL   : FIFO holds 2**DEPTH_LOG2 entries
//   COUNT  : current entry count
//   OVF    : sticky overflow flag
//   PERR   : sticky parity-error flag
//   FERR   : sticky framing/timeout-error flag
interface ps2_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  RD;
    logic                  CLR;
    logic [7:0]            RDATA;
    logic                  EMPTY;
    logic                  FULL;
    logic [DEPTH_LOG2:0]   COUNT;
    logic                  OVF;
    logic                  PERR;
    logic                  FERR;

    modport master (
        output RD, CLR,
        input  RDATA, EMPTY, FULL, COUNT, OVF, PERR, FERR
    );

    modport slave (
        input  RD, CLR,
        output RDATA, EMPTY, FULL, COUNT, OVF, PERR, FERR
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard frame receiver feeding a first-word fall-through FIFO
//
// Ports:
//   CLK      : system clock, all logic on rising edge
//   RST      : synchronous active-low reset
//   PS2CLK   : PS/2 clock from keyboard (asynchronous, input only)
//   PS2DATA  : PS/2 data from keyboard (asynchronous, input only)
//   bus      : ps2_rx_fifo_if.slave (RD, CLR, RDATA, EMPTY, FULL, COUNT, OVF, PERR, FERR)
module ps2_rx_fifo #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DEPTH_LOG2     = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            PS2CLK,
    input  logic            PS2DATA,
    ps2_rx_fifo_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]       TMAX     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    // Synchronizers and clock history; all idle-high so reset values are 1.
    logic ps2clk_s1_q, ps2clk_s2_q, ps2clk_hist_q;
    logic ps2data_s1_q, ps2data_s2_q;

    logic [0:0]            state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [9:0]            shift_q, shift_d;
    logic [TW-1:0]         timer_q, timer_d;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    logic ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;

    logic       fall;
    logic [9:0] frame_bits;
    logic       frame_done, timeout_evt;
    logic       parity_ok, stop_ok, frame_ok;
    logic       empty, full, pop, push, ovf_evt;

    assign fall = ps2clk_hist_q & ~ps2clk_s2_q;

    // Frame as it looks once the current bit is shifted in: [7:0] data, [8] parity, [9] stop.
    assign frame_bits = {ps2data_s2_q, shift_q[9:1]};
    assign parity_ok  = ^frame_bits[8:0];
    assign stop_ok    = frame_bits[9];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        timer_d     = timer_q;
        frame_done  = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                if (fall && !ps2data_s2_q) begin
                    state_d = RECV;
                end
            end
            default: begin
                if (fall) begin
                    timer_d = '0;
                    shift_d = frame_bits;
                    if (bit_cnt_q == 4'd9) begin
                        state_d    = IDLE;
                        bit_cnt_d  = '0;
                        frame_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (timer_q == TMAX) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    timer_d     = '0;
                    timeout_evt = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        endcase
    end

    assign frame_ok = frame_done & parity_ok & stop_ok;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign pop     = bus.RD & ~empty;
    assign push    = frame_ok & (~full | pop);
    assign ovf_evt = frame_ok & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Event wins over CLR so an error coinciding with a clear is not lost.
    always_comb begin
        ovf_d  = (ovf_q  & ~bus.CLR) | ovf_evt;
        perr_d = (perr_q & ~bus.CLR) | (frame_done & ~parity_ok);
        ferr_d = (ferr_q & ~bus.CLR) | (frame_done & ~stop_ok) | timeout_evt;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ps2clk_s1_q   <= 1'b1;
            ps2clk_s2_q   <= 1'b1;
            ps2clk_hist_q <= 1'b1;
            ps2data_s1_q  <= 1'b1;
            ps2data_s2_q  <= 1'b1;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            timer_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            perr_q        <= 1'b0;
            ferr_q        <= 1'b0;
        end else begin
            ps2clk_s1_q   <= PS2CLK;
            ps2clk_s2_q   <= ps2clk_s1_q;
            ps2clk_hist_q <= ps2clk_s2_q;
            ps2data_s1_q  <= PS2DATA;
            ps2data_s2_q  <= ps2data_s1_q;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            timer_q       <= timer_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            perr_q        <= perr_d;
            ferr_q        <= ferr_d;
        end
    end

    // Storage needs no reset: COUNT gates visibility of every entry.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= frame_bits[7:0];
        end
    end

    assign bus.RDATA = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.EMPTY = empty;
    assign bus.FULL  = full;
    assign bus.COUNT = count_q;
    assign bus.OVF   = ovf_q;
    assign bus.PERR  = perr_q;
    assign bus.FERR  = ferr_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;
    localparam int HALF = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic PS2CLK = 1'b1;
    logic PS2DATA = 1'b1;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [8];

    ps2_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    ps2_rx_fifo #(.TIMEOUT_CYCLES(200), .DEPTH_LOG2(4)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .PS2CLK  (PS2CLK),
        .PS2DATA (PS2DATA),
        .bus     (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // One PS/2 bit; optional RD/CLR strobe lands on the cycle the DUT sees this falling edge.
    task automatic send_bit(input logic b, input bit strobe_rd, input bit strobe_clr);
        PS2DATA = b;
        wait_cyc(HALF);
        PS2CLK = 1'b0;
        if (strobe_rd || strobe_clr) begin
            wait_cyc(2);
            bus.RD  = strobe_rd;
            bus.CLR = strobe_clr;
            wait_cyc(1);
            bus.RD  = 1'b0;
            bus.CLR = 1'b0;
            wait_cyc(HALF - 3);
        end else begin
            wait_cyc(HALF);
        end
        PS2CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                              input bit rd_at_stop, input bit clr_at_stop);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0, 1'b0);
        send_bit((~^d) ^ par_flip, 1'b0, 1'b0);
        send_bit(stop, rd_at_stop, clr_at_stop);
        wait_cyc(4);
    endtask

    task automatic pulse_rd();
        bus.RD = 1'b1;
        wait_cyc(1);
        bus.RD = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.CLR = 1'b1;
        wait_cyc(1);
        bus.CLR = 1'b0;
    endtask

    task automatic drain(input string name);
        logic [7:0] e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({name, "_rdata"}, 32'(bus.RDATA), 32'(e));
            pulse_rd();
        end
        check({name, "_empty"}, 32'(bus.EMPTY), 32'd1);
        check({name, "_rdata_empty"}, 32'(bus.RDATA), 32'h00);
    endtask

    initial begin
        bus.RD  = 1'b0;
        bus.CLR = 1'b0;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        wait_cyc(3);
        check("rst_empty", 32'(bus.EMPTY), 32'd1);
        check("rst_full",  32'(bus.FULL),  32'd0);
        check("rst_count", 32'(bus.COUNT), 32'd0);
        check("rst_rdata", 32'(bus.RDATA), 32'h00);
        check("rst_flags", {29'd0, bus.OVF, bus.PERR, bus.FERR}, 32'd0);
        RST = 1'b1;
        wait_cyc(2);

        // A falling edge with data 1 is not a start bit
        send_bit(1'b1, 1'b0, 1'b0);
        wait_cyc(4);

        // Table of frames: push valid bytes to scoreboard, check flags, clear them
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop, 1'b0, 1'b0);
            if (!vecs[i].exp_perr && !vecs[i].exp_ferr) sb.push_back(vecs[i].data);
            check($sformatf("vec%0d_perr", i), 32'(bus.PERR), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_ferr", i), 32'(bus.FERR), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_count", i), 32'(bus.COUNT), 32'(sb.size()));
            check($sformatf("vec%0d_empty", i), 32'(bus.EMPTY), 32'(sb.size() == 0));
            if (sb.size() > 0) check($sformatf("vec%0d_head", i), 32'(bus.RDATA), 32'(sb[0]));
            pulse_clr();
            check($sformatf("vec%0d_clr", i), {30'd0, bus.PERR, bus.FERR}, 32'd0);
        end
        drain("tbl");

        // RD while empty leaves pointers alone
        pulse_rd();
        pulse_rd();
        check("rdempty_count", 32'(bus.COUNT), 32'd0);
        send_frame(8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
        sb.push_back(8'h42);
        check("rdempty_count1", 32'(bus.COUNT), 32'd1);
        drain("rdempty");

        // Fill to full plus one overflow
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
            if (i <= 16) sb.push_back(8'(i));
        end
        check("full_full",  32'(bus.FULL),  32'd1);
        check("full_count", 32'(bus.COUNT), 32'd16);
        check("full_ovf",   32'(bus.OVF),   32'd1);
        check("full_rdata", 32'(bus.RDATA), 32'h01);
        pulse_clr();
        check("full_ovf_clr", 32'(bus.OVF), 32'd0);

        // Push coinciding with RD while full
        check("simul_head", 32'(bus.RDATA), 32'(sb[0]));
        send_frame(8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
        void'(sb.pop_front());
        sb.push_back(8'h77);
        check("simul_count", 32'(bus.COUNT), 32'd16);
        check("simul_ovf",   32'(bus.OVF),   32'd0);
        drain("full");

        // Error event in the same cycle as CLR keeps the flag
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b1);
        check("clr_race_perr", 32'(bus.PERR), 32'd1);
        pulse_clr();
        check("clr_after_race", 32'(bus.PERR), 32'd0);

        // Timeout mid-frame
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        wait_cyc(100);
        check("tmo_early", 32'(bus.FERR), 32'd0);
        wait_cyc(150);
        check("tmo_ferr",  32'(bus.FERR), 32'd1);
        check("tmo_empty", 32'(bus.EMPTY), 32'd1);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
        sb.push_back(8'hF0);
        check("tmo_next", 32'(bus.RDATA), 32'hF0);
        drain("tmo");
        pulse_clr();

        // Reset mid-frame with FIFO contents and a flag set
        send_frame(8'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        check("prerst_count", 32'(bus.COUNT), 32'd3);
        check("prerst_perr",  32'(bus.PERR),  32'd1);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'hA6 >> i) & 8'h01) != 0, 1'b0, 1'b0);
        RST = 1'b0;
        wait_cyc(1);
        RST = 1'b1;
        sb.delete();
        check("midrst_count", 32'(bus.COUNT), 32'd0);
        check("midrst_empty", 32'(bus.EMPTY), 32'd1);
        check("midrst_flags", {29'd0, bus.OVF, bus.PERR, bus.FERR}, 32'd0);
        wait_cyc(2);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        sb.push_back(8'h5A);
        check("postrst_count", 32'(bus.COUNT), 32'd1);
        check("postrst_flags", {29'd0, bus.OVF, bus.PERR, bus.FERR}, 32'd0);
        drain("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle cycles in a frame before abort (1 ms at 50 MHz).
REQ-002 SHALL have parameter DEPTH_LOG2, default 4: FIFO depth = 2**DEPTH_LOG2 entries.
REQ-003 SHALL have port CLK  in  1  system clock (50 MHz); all logic on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port PS2CLK  in  1  keyboard PS/2 clock, asynchronous.
REQ-006 SHALL have port PS2DATA  in  1  keyboard PS/2 data, asynchronous.
REQ-007 SHALL have port RD  in  1  one-cycle pop strobe from the bus interface.
REQ-008 SHALL have port CLR  in  1  one-cycle clear of the sticky error flags.
REQ-009 SHALL have port RDATA  out  8  head-of-FIFO byte (first-word fall-through).
REQ-010 SHALL have port EMPTY  out  1  FIFO holds 0 entries.
REQ-011 SHALL have port FULL  out  1  FIFO holds 2**DEPTH_LOG2 entries.
REQ-012 SHALL have port COUNT  out  DEPTH_LOG2+1  current entry count.
REQ-013 SHALL have ports OVF, PERR, FERR  out  1 each  sticky overflow, parity-error and framing/timeout-error flags.

Function
REQ-014 SHALL pass PS2CLK and PS2DATA through 2-FF synchronizers, plus one history register on the clock; falling edge = history 1 and synchronized 0.
REQ-015 SHALL sample synchronized PS2DATA only in the cycle a falling edge is detected.
REQ-016 SHALL implement states IDLE and RECV; IDLE -> RECV on a falling edge with data 0 (start bit); a start bit of 1 is ignored and the block stays in IDLE.
REQ-017 In RECV, SHALL shift 10 further bits: 8 data (LSB first), odd parity, stop; bit counter 0..9.
REQ-018 On the stop-bit edge, SHALL return to IDLE and validate the frame: ones in data+parity odd, and stop = 1.
REQ-019 Valid frame with FIFO not full: byte written on that clock edge; EMPTY low and COUNT incremented in the next cycle.
REQ-020 Parity bad: byte discarded, PERR set; stop bit 0: byte discarded, FERR set; both bad: both flags set.
REQ-021 Valid frame with FIFO full and no RD in the same cycle: byte discarded, OVF set, FIFO contents unchanged.
REQ-022 Push and RD in the same cycle: both performed, COUNT unchanged, no OVF even when full.
REQ-023 RD while EMPTY: ignored, pointers and COUNT unchanged.
REQ-024 RDATA SHALL equal the oldest entry when not EMPTY, and 8'h00 when EMPTY.
REQ-025 Pointers SHALL wrap modulo 2**DEPTH_LOG2; COUNT SHALL saturate neither above depth nor below 0.
REQ-026 In RECV, a cycle counter SHALL reset on each falling edge; on reaching TIMEOUT_CYCLES, partial frame discarded, FERR set, state -> IDLE.
REQ-027 CLR clears OVF, PERR and FERR next cycle; an error event in the same cycle as CLR leaves its flag set.
REQ-028 The block SHALL never drive PS2CLK or PS2DATA (receive only).

Reset
REQ-029 While RST=0 at a rising edge: state IDLE, bit and timeout counters 0, pointers 0, COUNT 0, EMPTY 1, FULL 0, RDATA 8'h00, OVF/PERR/FERR 0, synchronizers and history at 1.
REQ-030 RST asserted mid-frame SHALL discard the partial frame and FIFO contents; the next complete frame after release SHALL be received correctly.

Verification
REQ-031 Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,P=0,1), PS2CLK 12.5 kHz -> EMPTY 1->0, COUNT=1, RDATA=8'h1C; RD pulse -> EMPTY=1, RDATA=8'h00.
REQ-032 Frame 0x1C with parity 1 -> PERR=1, EMPTY stays 1; CLR pulse -> PERR=0.
REQ-033 17 valid frames 0x01..0x11, no RD -> FULL=1, COUNT=16, OVF=1, RDATA=8'h01; 16 RDs return 0x01..0x10 in order.
REQ-034 TIMEOUT_CYCLES=200; start bit + 4 data bits then PS2CLK held high -> FERR=1 after 200 cycles, EMPTY=1; next frame 0xF0 (P=1) -> RDATA=8'hF0.
REQ-035 RST low 1 cycle after 5th bit of a frame, COUNT=3 beforehand -> COUNT=0, EMPTY=1, flags 0; following frame 0x5A (P=1) -> COUNT=1, RDATA=8'h5A.
REQ-036 FIFO full, valid frame completes in same cycle as RD -> COUNT stays 16, OVF stays 0, new byte last in read order.
